// File: rtl/imm_extend.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend
// Description : Registered RV32I immediate generator for the decode stage.
//               Selects one of the I/S/B/J/U immediate layouts from the upper
//               instruction field and registers the 32-bit result one clock
//               later, together with a valid strobe and an illegal-select
//               flag.
// Ports       : clk       - clock, all state updates on the rising edge
//               reset     - synchronous, active-high reset
//               instr     - instruction bits [31:7] (bit n == instruction bit n)
//               immsrc    - format select: 000 I, 001 S, 010 B, 011 J, 100 U,
//                           101..111 illegal
//               in_valid  - instr/immsrc valid this cycle
//               immext    - registered extended immediate
//               out_valid - in_valid delayed by one cycle
//               illegal   - registered result came from an illegal immsrc
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:7] instr,
    input  logic [2:0]  immsrc,
    input  logic        in_valid,
    output logic [31:0] immext,
    output logic        out_valid,
    output logic        illegal
);

    localparam logic [2:0] c_SRC_I = 3'b000;
    localparam logic [2:0] c_SRC_S = 3'b001;
    localparam logic [2:0] c_SRC_B = 3'b010;
    localparam logic [2:0] c_SRC_J = 3'b011;
    localparam logic [2:0] c_SRC_U = 3'b100;

    logic        w_sign;
    logic [31:0] w_imm_mux;
    logic        w_illegal_dec;

    logic [31:0] w_immext_d;
    logic        w_out_valid_d;
    logic        w_illegal_d;

    logic [31:0] r_immext_q;
    logic        r_out_valid_q;
    logic        r_illegal_q;

    assign w_sign = instr[31];

    // Format mux. Only the bits belonging to the selected layout reach the
    // result; the illegal encodings decode to zero so an unknown select can
    // never leak instruction bits into the register.
    always_comb begin
        w_imm_mux     = 32'd0;
        w_illegal_dec = 1'b0;
        case (immsrc)
            c_SRC_I: w_imm_mux = {{20{w_sign}}, instr[31:20]};
            c_SRC_S: w_imm_mux = {{20{w_sign}}, instr[31:25], instr[11:7]};
            c_SRC_B: w_imm_mux = {{20{w_sign}}, instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            c_SRC_J: w_imm_mux = {{12{w_sign}}, instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            // U places instr[31] directly in bit 31, no extension needed.
            c_SRC_U: w_imm_mux = {instr[31:12], 12'd0};
            default: begin
                w_imm_mux     = 32'd0;
                w_illegal_dec = 1'b1;
            end
        endcase
    end

    // Data and flag only load on a valid input; otherwise they hold so the
    // last result stays visible while the strobe drops.
    always_comb begin
        w_immext_d    = r_immext_q;
        w_illegal_d   = r_illegal_q;
        w_out_valid_d = in_valid;
        if (in_valid) begin
            w_immext_d  = w_imm_mux;
            w_illegal_d = w_illegal_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_immext_q    <= 32'd0;
            r_out_valid_q <= 1'b0;
            r_illegal_q   <= 1'b0;
        end else begin
            r_immext_q    <= w_immext_d;
            r_out_valid_q <= w_out_valid_d;
            r_illegal_q   <= w_illegal_d;
        end
    end

    assign immext    = r_immext_q;
    assign out_valid = r_out_valid_q;
    assign illegal   = r_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend
// Description : Self-checking bench for imm_extend. Directed scenarios plus
//               randomized traffic compared against a behavioural model that
//               rebuilds the full 32-bit instruction word and derives each
//               immediate with shifts and masks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend;

    logic        clk;
    logic        reset;
    logic [31:7] instr;
    logic [2:0]  immsrc;
    logic        in_valid;
    logic [31:0] immext;
    logic        out_valid;
    logic        illegal;

    int          n_checks;
    int          n_errors;

    // Expected register contents, advanced once per clock by tick().
    logic [31:0] m_imm;
    logic        m_ill;
    logic        m_vld;

    imm_extend u_dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .immsrc    (immsrc),
        .in_valid  (in_valid),
        .immext    (immext),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate, derived from the ISA bit placements using
    // arithmetic shifts of the whole instruction word.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
        logic signed [31:0] s;
        s = $signed(ins);
        case (sel)
            3'd0: ref_imm = 32'(s >>> 20);
            3'd1: ref_imm = (32'(s >>> 20) & ~32'h1F) | ((ins >> 7) & 32'h1F);
            3'd2: ref_imm = (32'(s >>> 19) & 32'hFFFFF000) | ((ins << 4) & 32'h800)
                          | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
            3'd3: ref_imm = (32'(s >>> 11) & 32'hFFF00000) | (ins & 32'h000FF000)
                          | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
            3'd4: ref_imm = ins & 32'hFFFFF000;
            default: ref_imm = 32'd0;
        endcase
    endfunction

    // Advance the model from the inputs currently driven, then step one clock.
    task automatic tick();
        logic [31:0] ins;
        ins = {instr, 7'd0};
        if (reset) begin
            m_imm = 32'd0;
            m_ill = 1'b0;
            m_vld = 1'b0;
        end else if (in_valid) begin
            m_imm = ref_imm(ins, immsrc);
            m_ill = (immsrc >= 3'd5);
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [24:0] ins, input logic [2:0] sel, input logic vld);
        instr    = ins;
        immsrc   = sel;
        in_valid = vld;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(25'h1FFFFFF, 3'd0, 1'b1);
        tick();
        tick();
        n_checks++;
        if (immext !== 32'h0 || out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: immext=%h out_valid=%b illegal=%b, required 00000000/0/0",
                     immext, out_valid, illegal);
        end
        reset = 1'b0;
    endtask

    task automatic test_i_s();
        drive(25'h000123, 3'd0, 1'b1);
        tick();
        n_checks++;
        if (immext !== 32'h0 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL i_fmt: immext=%h out_valid=%b, required 00000000/1", immext, out_valid);
        end
        drive(25'h000041, 3'd1, 1'b1);
        tick();
        n_checks++;
        if (immext !== 32'h1 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL s_fmt: immext=%h out_valid=%b, required 00000001/1", immext, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] ins_t [3];
        logic [2:0]  sel_t [3];
        logic [31:0] exp_t [3];
        ins_t = '{25'h010222, 25'h080400, 25'h0ABCDE};
        sel_t = '{3'd2, 3'd3, 3'd4};
        exp_t = '{32'h00000002, 32'h00020040, 32'h055E6000};
        for (int i = 0; i < 3; i++) begin
            drive(ins_t[i], sel_t[i], 1'b1);
            tick();
            n_checks++;
            if (immext !== exp_t[i] || out_valid !== 1'b1 || illegal !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b[%0d]: immext=%h out_valid=%b illegal=%b, required %h/1/0",
                         i, immext, out_valid, illegal, exp_t[i]);
            end
        end
    endtask

    task automatic test_sign_ext();
        logic [31:0] exp_t [5];
        exp_t = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFF000};
        for (int i = 0; i < 5; i++) begin
            drive(25'h1FFFFFF, 3'(i), 1'b1);
            tick();
            n_checks++;
            if (immext !== exp_t[i] || out_valid !== 1'b1 || illegal !== 1'b0) begin
                n_errors++;
                $display("FAIL sign_ext[sel=%0d]: immext=%h out_valid=%b illegal=%b, required %h/1/0",
                         i, immext, out_valid, illegal, exp_t[i]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int i = 5; i < 8; i++) begin
            drive(25'h1FFFFFF, 3'(i), 1'b1);
            tick();
            n_checks++;
            if (immext !== 32'h0 || illegal !== 1'b1 || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL illegal[sel=%0d]: immext=%h illegal=%b out_valid=%b, required 00000000/1/1",
                         i, immext, illegal, out_valid);
            end
        end
        drive(25'h1FFFFFF, 3'd0, 1'b1);
        tick();
        n_checks++;
        if (immext !== 32'hFFFFFFFF || illegal !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_clear: immext=%h illegal=%b, required ffffffff/0", immext, illegal);
        end
    endtask

    task automatic test_hold();
        drive(25'h1FFFFFF, 3'd0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(25'($urandom), 3'($urandom_range(0, 7)), 1'b0);
            tick();
            n_checks++;
            if (immext !== 32'hFFFFFFFF || out_valid !== 1'b0 || illegal !== 1'b0) begin
                n_errors++;
                $display("FAIL hold[%0d]: immext=%h out_valid=%b illegal=%b, required ffffffff/0/0",
                         i, immext, out_valid, illegal);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(25'h1FFFFFF, 3'd3, 1'b1);
        tick();
        drive(25'h1FFFFFF, 3'd0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (immext !== 32'h0 || out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: immext=%h out_valid=%b illegal=%b, required 00000000/0/0",
                     immext, out_valid, illegal);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            drive(25'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
            tick();
            n_checks++;
            if (immext !== m_imm || out_valid !== m_vld || illegal !== m_ill) begin
                n_errors++;
                $display("FAIL random[%0d]: immext=%h out_valid=%b illegal=%b, required %h/%b/%b",
                         i, immext, out_valid, illegal, m_imm, m_vld, m_ill);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_imm    = 32'd0;
        m_ill    = 1'b0;
        m_vld    = 1'b0;
        reset    = 1'b1;
        drive(25'd0, 3'd0, 1'b0);
        #2;
        test_reset();
        test_i_s();
        test_back_to_back();
        test_sign_ext();
        test_illegal();
        test_hold();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_extend.md
Name: imm_extend

Overview:
Registered RISC-V immediate generator for the decode stage. It takes the upper instruction field instr[31:7] and a 3-bit immediate-format select. It produces the 32-bit sign- or zero-positioned immediate for the I, S, B, J and U formats one clock later. An illegal-select flag and a valid strobe travel with the result.

Parameters:
None. Data widths are fixed by the RV32I ISA: 25-bit field in, 32-bit immediate out.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
instr  input  25  instruction bits [31:7]; port bit index n equals instruction bit n (declared [31:7])
immsrc  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101–111 illegal
in_valid  input  1  instr/immsrc are valid this cycle
immext  output  32  extended immediate, registered
out_valid  output  1  immext is valid; equals in_valid delayed by one cycle
illegal  output  1  the registered result came from an illegal immsrc

Behaviour:
- One clock; reset is synchronous and active-high. When reset is sampled high at a rising clk edge: immext=0, out_valid=0, illegal=0. Reset overrides any in_valid in the same cycle.
- Combinational format mux, where s = instr[31]:
  - I (000): {20{s}}, instr[31:20]
  - S (001): {20{s}}, instr[31:25], instr[11:7]
  - B (010): {20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0
  - J (011): {12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0
  - U (100): instr[31:12], 12'b0. No sign extension is needed; instr[31] lands in bit 31.
  - 101/110/111: result 0 and illegal flag 1.
- Latency is exactly 1 cycle. On each non-reset edge with in_valid=1, these register from the current inputs: immext ← mux result; illegal ← (immsrc ≥ 101); out_valid ← 1.
- On a non-reset edge with in_valid=0: out_valid ← 0; immext and illegal hold their previous values.
- No back-pressure. A new input is accepted every cycle, so back-to-back valid inputs yield back-to-back outputs.
- The flops must not depend on any bits outside the selected format.
- B and J results always have bit 0 = 0. U results always have bits [11:0] = 0.
- Asserting reset mid-stream drops the in-flight result: out_valid=0 on the following cycle.
- No X propagation from an undefined immsrc. Every encoding is fully decoded.

Test Plan:
- Reset: hold reset high for 2 edges with in_valid=1 → immext=0x00000000, out_valid=0, illegal=0.
- I and S formats. instr=25'h000123, immsrc=000, in_valid=1 → next cycle immext=0x00000000, out_valid=1. Then instr=25'h000041, immsrc=001 → immext=0x00000001.
- B, J and U formats, back-to-back valid cycles:
  - instr=25'h010222, immsrc=010 → immext=0x00000002
  - then instr=25'h080400, immsrc=011 → immext=0x00020040
  - then instr=25'h0ABCDE, immsrc=100 → immext=0x055E6000
  - results appear on consecutive cycles.
- Sign extension: instr=25'h1FFFFFF with each select:
  - I → 0xFFFFFFFF
  - S → 0xFFFFFFFF
  - B → 0xFFFFFFFE
  - J → 0xFFFFFFFE
  - U → 0xFFFFF000
- Illegal select: immsrc=101, 110 and 111 with instr=25'h1FFFFFF → immext=0, illegal=1. A following legal I-type cycle clears illegal to 0.
- Hold and mid-stream reset:
  - A valid I-type with instr=25'h1FFFFFF, then in_valid=0 for 3 cycles → immext holds 0xFFFFFFFF and out_valid=0.
  - Assert reset in the same cycle as a valid input → next cycle immext=0 and out_valid=0.
